fdiv: RTL and testbench
=======================

# fdiv

Sequential single-precision floating-point divider, the inverse of the team's combinational `fmul` multiplier. It computes `s = a / b` on IEEE-754 binary32 operands with a radix-2 restoring mantissa divider that produces one quotient bit per cycle. A start/done handshake exposes it to the datapath. The number formats match `fmul`:
- normal operands only;
- 8-bit exponent with wrap, no overflow or underflow saturation;
- round-half-up on the first discarded bit.

## Interface
Parameters:
- none.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request. Sampled only in IDLE.
- `a`  input  32  dividend, binary32. Captured on the accepted start edge.
- `b`  input  32  divisor, binary32. Captured on the accepted start edge.
- `s`  output  32  quotient. Holds its value until the next completion or reset.
- `busy`  output  1  high from the accepted start edge until completion.
- `done`  output  1  one-cycle pulse when `s` is updated.

## Operation
- States: IDLE, DIV, NORM.
  - IDLE → DIV on `start`.
  - DIV → NORM after 26 iterations.
  - NORM → IDLE unconditionally.
- Reset: `state` = IDLE, `s` = 0, `busy` = 0, `done` = 0. All internal registers are cleared.
- Start edge (IDLE and `start`=1) latches the following:
  - sign = `a[31]^b[31]`;
  - exp = `a[30:23] - b[30:23] + 127`, held in a 10-bit register;
  - ma = `{1,a[22:0]}`, mb = `{1,b[22:0]}`;
  - remainder = ma, quotient register Q (26 bits) = 0, iteration counter = 0.
- DIV, each cycle:
  - trial = `rem - mb`;
  - if trial ≥ 0: rem ← `trial<<1`, shift 1 into Q;
  - else: rem ← `rem<<1`, shift 0 into Q;
  - counter increments; after 26 iterations Q = floor(ma·2^25/mb).
  - The remainder is 26 bits wide, so no overflow can occur.
- NORM:
  - If `Q[25]`=1: mant = `Q[24:2]`, rnd = `Q[1]`, exp unchanged.
  - Else: mant = `Q[23:1]`, rnd = `Q[0]`, exp ← exp-1.
  - Round: mant + rnd. A carry out of 23 bits sets mant = 0 and exp ← exp+1.
  - Output: `s = {sign, exp[7:0], mant}`, with exp truncated to 8 bits as in `fmul`.
  - `done` = 1 for this cycle only.
- `start` while `busy`=1 is ignored. Operands are not re-latched.
- `start` held high across completion starts a new operation on the first IDLE cycle after completion.
- Zero, denormal, Inf and NaN operands are not handled, except as described under Configuration.

## Timing
- Start sampled at edge E0.
- DIV occupies edges E1..E26. NORM result is registered at E27.
- `done` and the new `s` are visible after E27. Latency is 27 cycles.
- `busy` rises after E0 and falls after E27, at the same edge where `done` rises.
- Throughput: one result per 28 cycles if `start` is held continuously.
- `rst` asserted in any state returns the block to IDLE immediately (asynchronously):
  - outputs go to their reset values;
  - any in-flight operation is discarded, and no `done` pulse is issued for it.

## Configuration
- `FDIV_ZERO_EN` defined:
  - a start with `b[30:23]==0` bypasses DIV and goes straight to NORM;
  - NORM produces `s = {sign, 8'hFF, 23'h0}` (signed infinity);
  - `done` follows at E1, so latency is 1 cycle and `busy` is high for 1 cycle.
- `FDIV_ZERO_EN` undefined:
  - no zero check; such operands take the normal 27-cycle path;
  - the value of `s` is unspecified.

## Test plan
- Reset, then `a`=0x40C00000 (6.0), `b`=0x40000000 (2.0), start → after 27 cycles `done`=1 for one cycle, `s`=0x40400000, `busy` low the same cycle.
- `a`=0x3F800000, `b`=0x40400000 (1/3) → `s`=0x3EAAAAAB (normalise path plus round-up). `a`=`b`=0x3F800000 → `s`=0x3F800000.
- `a`=0xC0F00000 (-7.5), `b`=0x40200000 (2.5) → `s`=0xC0400000. Pulse `start` with other operands at cycle 5 of the operation → ignored, result unchanged, single `done`.
- Hold `start` high for 60 cycles with 6.0/2.0 → `done` pulses exactly at cycles 27 and 55, `s`=0x40400000 both times.
- Assert `rst` at DIV iteration 10 → `busy`, `done` and `s` are 0 immediately. Release `rst` and issue a new 6.0/2.0 start → correct result after 27 cycles, no stray `done`.
- With `FDIV_ZERO_EN` defined: `a`=0x3F800000, `b`=0x00000000 → `done` one cycle after start, `s`=0x7F800000. With `a`=0xBF800000 → `s`=0xFF800000.

Source files
------------

// File: rtl/fdiv_if.sv
// Start/done handshake and operand/result bus of the fdiv sequential divider.
interface fdiv_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        busy;
    logic        done;

    modport master (output start, a, b, input s, busy, done);
    modport slave  (input start, a, b, output s, busy, done);
endinterface

// File: rtl/fdiv.sv
// Sequential binary32 divider: radix-2 restoring mantissa divide, one quotient bit per cycle.
// Optional macro FDIV_ZERO_EN turns a zero-exponent divisor into a 1-cycle signed-infinity result.
module fdiv (
    input  logic   clk,
    input  logic   rst,
    fdiv_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_mb;
    logic [25:0] r_rem;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_zero;
    logic [31:0] r_s;
    logic        r_busy;
    logic        r_done;

    logic [9:0]  w_start_exp;
    logic [26:0] w_trial;
    logic [22:0] w_mant_pre;
    logic        w_rnd;
    logic [9:0]  w_exp_norm;
    logic [23:0] w_mant_sum;
    logic [22:0] w_mant;
    logic [9:0]  w_exp_rnd;

    assign w_start_exp = {2'b00, bus.a[30:23]} - {2'b00, bus.b[30:23]} + 10'd127;
    // Bit 26 of the widened difference is the borrow: set means rem < mb.
    assign w_trial     = {1'b0, r_rem} - {3'b000, r_mb};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        w_mant_pre = r_q[23:1];
        w_rnd      = r_q[0];
        w_exp_norm = r_exp - 10'd1;
        if (r_q[25]) begin
            w_mant_pre = r_q[24:2];
            w_rnd      = r_q[1];
            w_exp_norm = r_exp;
        end
        // A rounding carry leaves the low 23 sum bits at zero and bumps the exponent.
        w_mant_sum = {1'b0, w_mant_pre} + {23'd0, w_rnd};
        w_mant     = w_mant_sum[22:0];
        w_exp_rnd  = w_mant_sum[23] ? (w_exp_norm + 10'd1) : w_exp_norm;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mb    <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign <= bus.a[31] ^ bus.b[31];
                        r_exp  <= w_start_exp;
                        r_mb   <= {1'b1, bus.b[22:0]};
                        r_rem  <= {2'b01, bus.a[22:0], 1'b0} >> 1;
                        r_q    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef FDIV_ZERO_EN
                        r_zero  <= (bus.b[30:23] == 8'd0);
                        r_state <= (bus.b[30:23] == 8'd0) ? S_NORM : S_DIV;
`else
                        r_zero  <= 1'b0;
                        r_state <= S_DIV;
`endif
                    end
                end
                S_DIV: begin
                    if (!w_trial[26]) begin
                        r_rem <= {w_trial[24:0], 1'b0};
                        r_q   <= {r_q[24:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[24:0], 1'b0};
                        r_q   <= {r_q[24:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd25) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_s     <= r_zero ? {r_sign, 8'hFF, 23'd0}
                                      : {r_sign, w_exp_rnd[7:0], w_mant};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s    = r_s;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_fdiv.sv
// Directed self-checking bench for fdiv with hand-computed quotients and cycle-exact handshake checks.
module tb_fdiv;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fdiv_if bus ();

    fdiv u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // One operation from start edge E0 to done; glitch_cyc > 0 pulses start after that edge.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_s, input int exp_lat, input int glitch_cyc);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.a     = op_a;
        bus.b     = op_b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (glitch_cyc > 0 && cyc == glitch_cyc) begin
                bus.start = 1'b1;
                bus.a     = 32'h3F800000;
                bus.b     = 32'h40400000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_s"}, bus.s, exp_s);
        check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_s_hold"}, bus.s, exp_s);
    endtask

    initial begin
        int d1, d2, n_done, cyc;
        logic [31:0] s1, s2;
        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s", bus.s, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);
        run_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27, 0);
        run_op("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 27, 0);
        run_op("neg_glitch", 32'hC0F00000, 32'h40200000, 32'hC0400000, 27, 5);
        n_done = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("glitch_no_extra_done", 32'(n_done), 32'd0);

        // start held high: results at cycles 27 and 55 after the first accepted edge
        @(negedge clk);
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        d1 = -1;
        d2 = -1;
        s1 = '0;
        s2 = '0;
        n_done = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_done++;
                if (d1 < 0) begin
                    d1 = c;
                    s1 = bus.s;
                end else if (d2 < 0) begin
                    d2 = c;
                    s2 = bus.s;
                end
            end
        end
        bus.start = 1'b0;
        check("held_done_count", 32'(n_done), 32'd2);
        check("held_first_cycle", 32'(d1), 32'd27);
        check("held_second_cycle", 32'(d2), 32'd55);
        check("held_first_s", s1, 32'h40400000);
        check("held_second_s", s2, 32'h40400000);
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("held_drain_done", 32'(bus.done), 32'd1);

        // asynchronous reset in the middle of DIV
        run_op("pre_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 27, 0);
        @(negedge clk);
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_s", bus.s, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("post_rst_no_stray_done", 32'(n_done), 32'd0);
        run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);

`ifdef FDIV_ZERO_EN
        run_op("zero_pos", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
        run_op("zero_neg", 32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
